// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: the stage occupancy
// states and the NOP encoding integrators tie to def_val.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        FULL      = 2'd1,
        FULL_SKID = 2'd2
    } stage_state_t;

    localparam logic [31:0] PIPE_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used to accumulate stall cycles at a stage boundary.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Stops at all-ones so long stalls never wrap back to a small count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush-to-bubble and a stall counter.
// Define PIPE_STAGE_SKID_EN to add a skid buffer and a fully registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     def_val,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [N-1:0]     out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] stall_cnt
);

    stage_state_t state_q, state_d;
    logic [N-1:0] main_q, main_d;
    logic         in_fire;
    logic         out_fire;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic [N-1:0] skid_q, skid_d;
    logic         ready_q;

    // in_ready comes straight from a flop: low only while the skid holds a beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= (state_d != FULL_SKID);
        end
    end

    assign in_ready = ready_q;
`else
    assign in_ready = !out_valid || out_ready;
`endif

    // Flush wins over any load; a beat accepted in that cycle is dropped.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_d  = skid_q;
`endif
        if (flush) begin
            state_d = EMPTY;
            main_d  = def_val;
`ifdef PIPE_STAGE_SKID_EN
            skid_d  = '0;
`endif
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = FULL;
                        main_d  = in_data;
                    end
                end
                FULL: begin
                    if (out_fire && in_fire) begin
                        main_d = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                        main_d  = def_val;
                    end
`ifdef PIPE_STAGE_SKID_EN
                    else if (in_fire) begin
                        state_d = FULL_SKID;
                        skid_d  = in_data;
                    end
`endif
                end
`ifdef PIPE_STAGE_SKID_EN
                FULL_SKID: begin
                    if (out_fire) begin
                        state_d = FULL;
                        main_d  = skid_q;
                    end
                end
`endif
                default: begin
                    state_d = EMPTY;
                    main_d  = def_val;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= def_val;
`ifdef PIPE_STAGE_SKID_EN
            skid_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
`ifdef PIPE_STAGE_SKID_EN
            skid_q  <= skid_d;
`endif
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_valid && !out_ready),
        .cnt (stall_cnt)
    );

endmodule
